pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline: F -> f2d -> D -> d2e -> E -> e2m -> M -> m2w -> W.
- Drives the stall and flush inputs of every inter-stage pipeline register, plus the PC hold.
- Resolves data-memory wait, multi-cycle mul/div occupancy, taken-branch redirect, load-use hazards and instruction-memory wait, using one fixed priority order.
- Holds a small FSM and countdown for mul/div, and a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline
// F -> f2d -> D -> d2e -> E -> e2m -> M -> m2w -> W.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   dec_rs_addr/dec_rt_addr     source register indices of the D instruction
//   dec_uses_rs/dec_uses_rt     D instruction actually reads rs / rt
//   exec_mem_read, exec_rd_addr E instruction is a load, and its destination
//   exec_branch_taken           E resolved a taken branch/jump
//   exec_muldiv_start           E instruction is a multi-cycle mul/div
//   inst_ready                  instruction memory returns data this cycle
//   mem_req, mem_ready          M-stage data access outstanding / completing
//   stall_pc, stall_*           hold the PC / named pipeline register
//   flush_*                     load a bubble into the named register
//   muldiv_busy, muldiv_done    mul/div occupying E / final mul/div cycle
//   stall_cycles                saturating count of cycles with stall_pc high
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULDIV_CYCLES  = 32,
  parameter int CNT_WIDTH      = 6,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic                      dec_uses_rs,
  input  logic                      dec_uses_rt,
  input  logic                      exec_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic                      exec_branch_taken,
  input  logic                      exec_muldiv_start,
  input  logic                      inst_ready,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      stall_pc,
  output logic                      stall_f2d,
  output logic                      stall_d2e,
  output logic                      stall_e2m,
  output logic                      stall_m2w,
  output logic                      flush_f2d,
  output logic                      flush_d2e,
  output logic                      flush_e2m,
  output logic                      flush_m2w,
  output logic                      muldiv_busy,
  output logic                      muldiv_done,
  output logic [PERF_WIDTH-1:0]     stall_cycles
);

  typedef enum logic {RUN, MULDIV} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 mem_wait;
  logic                 load_use;
  logic                 rs_hit;
  logic                 rt_hit;

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (v == '1) ? v : v + PERF_WIDTH'(1);
  endfunction

  assign mem_wait = mem_req & ~mem_ready;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs_hit   = dec_uses_rs & (dec_rs_addr == exec_rd_addr);
  assign rt_hit   = dec_uses_rt & (dec_rt_addr == exec_rd_addr);
  assign load_use = exec_mem_read & (exec_rd_addr != '0) & (rs_hit | rt_hit);

  // The issuing cycle (still in RUN) already counts as busy, so the unit
  // occupies E for MULDIV_CYCLES cycles; cnt==0 is the hand-off cycle.
  assign muldiv_busy = ((state == RUN) & exec_muldiv_start) |
                       ((state == MULDIV) & (cnt != '0));
  assign muldiv_done = (state == MULDIV) & (cnt == '0);

  // Fixed priority: a lower row is only visible when no higher row matches.
  // A branch deferred by mem_wait or mul/div stays in E and re-asserts later.
  always_comb begin
    stall_pc  = 1'b0;
    stall_f2d = 1'b0;
    stall_d2e = 1'b0;
    stall_e2m = 1'b0;
    stall_m2w = 1'b0;
    flush_f2d = 1'b0;
    flush_d2e = 1'b0;
    flush_e2m = 1'b0;
    flush_m2w = 1'b0;
    if (mem_wait) begin
      stall_pc  = 1'b1;
      stall_f2d = 1'b1;
      stall_d2e = 1'b1;
      stall_e2m = 1'b1;
      flush_m2w = 1'b1;
    end else if (muldiv_busy) begin
      stall_pc  = 1'b1;
      stall_f2d = 1'b1;
      stall_d2e = 1'b1;
      flush_e2m = 1'b1;
    end else if (exec_branch_taken) begin
      flush_f2d = 1'b1;
      flush_d2e = 1'b1;
    end else if (load_use) begin
      stall_pc  = 1'b1;
      stall_f2d = 1'b1;
      flush_d2e = 1'b1;
    end else if (!inst_ready) begin
      stall_pc  = 1'b1;
      flush_f2d = 1'b1;
    end
  end

  // Mul/div sequencing; everything freezes while the data memory waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!mem_wait) begin
      case (state)
        RUN: begin
          if (exec_muldiv_start) begin
            state <= MULDIV;
            cnt   <= CNT_WIDTH'(MULDIV_CYCLES - 1);
          end
        end
        MULDIV: begin
          // start seen at cnt==0 is the finishing instruction itself.
          if (cnt == '0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_pc) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int N    = 4;
  localparam int PW   = 4;
  localparam int PMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    dec_rs_addr, dec_rt_addr, exec_rd_addr;
  logic          dec_uses_rs, dec_uses_rt, exec_mem_read;
  logic          exec_branch_taken, exec_muldiv_start, inst_ready, mem_req, mem_ready;
  logic          stall_pc, stall_f2d, stall_d2e, stall_e2m, stall_m2w;
  logic          flush_f2d, flush_d2e, flush_e2m, flush_m2w, muldiv_busy, muldiv_done;
  logic [PW-1:0] stall_cycles;
  logic [10:0]   obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a mul/div in flight and how many cycles of it
  // have been completed (issue cycle counts as 1).
  bit md_active;
  int md_elapsed;
  int perf;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .MULDIV_CYCLES(N), .CNT_WIDTH(3), .PERF_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .exec_mem_read(exec_mem_read), .exec_rd_addr(exec_rd_addr),
    .exec_branch_taken(exec_branch_taken), .exec_muldiv_start(exec_muldiv_start),
    .inst_ready(inst_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_f2d(stall_f2d), .stall_d2e(stall_d2e),
    .stall_e2m(stall_e2m), .stall_m2w(stall_m2w),
    .flush_f2d(flush_f2d), .flush_d2e(flush_d2e), .flush_e2m(flush_e2m),
    .flush_m2w(flush_m2w), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // bit order: stall pc,f2d,d2e,e2m,m2w | flush f2d,d2e,e2m,m2w | busy, done
  assign obs = {stall_pc, stall_f2d, stall_d2e, stall_e2m, stall_m2w,
                flush_f2d, flush_d2e, flush_e2m, flush_m2w, muldiv_busy, muldiv_done};

  function automatic logic [10:0] exp_out();
    logic mw, lu, busy, done;
    logic [10:0] v;
    mw   = mem_req && !mem_ready;
    lu   = exec_mem_read && (exec_rd_addr != 0) &&
           ((dec_uses_rs && dec_rs_addr == exec_rd_addr) ||
            (dec_uses_rt && dec_rt_addr == exec_rd_addr));
    busy = md_active ? (md_elapsed < N) : exec_muldiv_start;
    done = md_active && (md_elapsed == N);
    v = '0;
    v[1] = busy;
    v[0] = done;
    if (mw)                     v[10:2] = 9'b11110_0001;
    else if (busy)              v[10:2] = 9'b11100_0010;
    else if (exec_branch_taken) v[10:2] = 9'b00000_1100;
    else if (lu)                v[10:2] = 9'b11000_0100;
    else if (!inst_ready)       v[10:2] = 9'b10000_1000;
    return v;
  endfunction

  task automatic model_reset();
    md_active  = 0;
    md_elapsed = 0;
    perf       = 0;
  endtask

  // Advance one clock edge, updating the model from the pre-edge view.
  task automatic tick();
    logic [10:0] e;
    e = exp_out();
    @(posedge clk);
    if (rst_n) begin
      if (e[10] && perf < PMAX) perf++;
      if (!e[2]) begin
        if (md_active) begin
          if (md_elapsed == N) md_active = 0;
          else md_elapsed++;
        end else if (exec_muldiv_start) begin
          md_active  = 1;
          md_elapsed = 1;
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    dec_rs_addr = 0; dec_rt_addr = 0; exec_rd_addr = 0;
    dec_uses_rs = 0; dec_uses_rt = 0; exec_mem_read = 0;
    exec_branch_taken = 0; exec_muldiv_start = 0;
    inst_ready = 1; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    model_reset();
    #3;
    n_checks++;
    if (obs !== 11'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want %b", obs, 11'b0);
    end
    n_checks++;
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_perf: got %0d want 0", stall_cycles);
    end
    inst_ready = 0;
    #1;
    n_checks++;
    if (obs !== 11'b10000_1000_00) begin
      n_fail++; $display("FAIL reset_comb_inst_wait: got %b want %b", obs, 11'b10000100000);
    end
    inst_ready = 1;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      set_idle();
      exec_mem_read = 1; exec_rd_addr = (k == 0) ? 5'd5 : 5'd0;
      dec_uses_rs = 1; dec_rs_addr = (k == 0) ? 5'd5 : 5'd0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out() || obs !== ((k == 0) ? 11'b11000_0100_00 : 11'b0)) begin
        n_fail++; $display("FAIL load_use rd=%0d: got %b want %b", exec_rd_addr, obs, exp_out());
      end
      tick();
      set_idle();
      @(negedge clk);
      n_checks++;
      if (obs !== 11'b0) begin
        n_fail++; $display("FAIL load_use_after rd=%0d: got %b want 0", k == 0 ? 5 : 0, obs);
      end
      tick();
    end
  endtask

  // Optionally inserts a 3-cycle data-memory wait starting at cycle 1.
  task automatic test_muldiv(input bit with_wait, input int want_busy);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    set_idle();
    for (int i = 0; i < 12; i++) begin
      exec_muldiv_start = (i == 0) || md_active;
      mem_req   = with_wait && i >= 1 && i <= 3;
      mem_ready = 0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++; $display("FAIL muldiv w=%0d cyc %0d: got %b want %b", with_wait, i, obs, exp_out());
      end
      if (mem_req) begin
        n_checks++;
        if (!(stall_e2m && flush_m2w && !flush_e2m && muldiv_busy)) begin
          n_fail++; $display("FAIL muldiv_memwait cyc %0d: got %b want e2m stall, m2w flush", i, obs);
        end
      end
      if (muldiv_busy) busy_n++;
      if (muldiv_done) begin done_n++; done_at = i; end
      tick();
    end
    n_checks++;
    if (busy_n != want_busy || done_n != 1 || done_at != want_busy) begin
      n_fail++;
      $display("FAIL muldiv_len w=%0d: got busy=%0d done=%0d at %0d want busy=%0d done=1 at %0d",
               with_wait, busy_n, done_n, done_at, want_busy, want_busy);
    end
    set_idle();
  endtask

  task automatic test_branch_priority();
    set_idle();
    exec_branch_taken = 1; inst_ready = 0;
    exec_mem_read = 1; exec_rd_addr = 7; dec_uses_rt = 1; dec_rt_addr = 7;
    @(negedge clk);
    n_checks++;
    if (obs !== 11'b00000_1100_00 || obs !== exp_out()) begin
      n_fail++; $display("FAIL branch_priority: got %b want %b", obs, 11'b00000110000);
    end
    tick();
    set_idle();
  endtask

  task automatic test_branch_during_muldiv();
    set_idle();
    for (int i = 0; i < 6; i++) begin
      exec_muldiv_start = (i < N);
      exec_branch_taken = (i < N) || (i == N + 1);
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out()) begin
        n_fail++; $display("FAIL branch_md cyc %0d: got %b want %b", i, obs, exp_out());
      end
      if (i < N) begin
        n_checks++;
        if (flush_f2d || flush_d2e) begin
          n_fail++; $display("FAIL branch_md_deferred cyc %0d: got flush %b%b want 00", i, flush_f2d, flush_d2e);
        end
      end
      if (i == N + 1) begin
        n_checks++;
        if (!(flush_f2d && flush_d2e && !stall_pc)) begin
          n_fail++; $display("FAIL branch_md_release: got %b want flush_f2d/d2e", obs);
        end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_muldiv();
    set_idle();
    exec_muldiv_start = 1;
    tick();
    tick();
    exec_muldiv_start = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 11'b0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_mid_md: got %b perf %0d want 0 perf 0", obs, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1;
    // no done pulse may follow the aborted mul/div
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 11'b0) begin
        n_fail++; $display("FAIL reset_mid_md_after cyc %0d: got %b want 0", i, obs);
      end
      tick();
    end
    inst_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 4'd10) begin
      n_fail++; $display("FAIL perf_count10: got %0d want 10", stall_cycles);
    end
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 4'(PMAX)) begin
      n_fail++; $display("FAIL perf_saturate: got %0d want %0d", stall_cycles, PMAX);
    end
    set_idle();
  endtask

  task automatic test_random();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      dec_rs_addr       = 5'($urandom_range(0, 3));
      dec_rt_addr       = 5'($urandom_range(0, 3));
      exec_rd_addr      = 5'($urandom_range(0, 3));
      dec_uses_rs       = 1'($urandom_range(0, 1));
      dec_uses_rt       = 1'($urandom_range(0, 1));
      exec_mem_read     = ($urandom_range(0, 2) == 0);
      exec_branch_taken = ($urandom_range(0, 4) == 0);
      exec_muldiv_start = ($urandom_range(0, 5) == 0);
      inst_ready        = ($urandom_range(0, 4) != 0);
      mem_req           = ($urandom_range(0, 3) == 0);
      mem_ready         = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out() || stall_cycles !== 4'(perf)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b perf %0d want %b perf %0d",
                 i, obs, stall_cycles, exp_out(), perf);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv(1'b0, N);
    test_muldiv(1'b1, N + 3);
    test_branch_priority();
    test_branch_during_muldiv();
    test_reset_mid_muldiv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
